// File: rtl/bc_pkg.sv
// Shared defaults for the avoid<->ctrl link buffer: word width, depth and stall-counter width.
package bc_pkg;

    localparam int BC_WIDTH  = 16;
    localparam int BC_DEPTH  = 16;
    localparam int BC_STAT_W = 16;

    localparam logic [BC_STAT_W-1:0] BC_STAT_ONE = {{(BC_STAT_W-1){1'b0}}, 1'b1};

endpackage

// File: rtl/bc_fifo.sv
// Single-direction FIFO with valid/ready on both ends, flush, occupancy count and almost-full flag.
// Latency: a word pushed at edge N is at out_data after edge N; count/afull are registered.
// Backpressure: in_rdy = !full from registered count only; a full FIFO refuses a push even while popping.
// Optional BC_LINK_STATS_EN adds a saturating stall counter (cycles with in_valid && !in_rdy).
module bc_fifo
    import bc_pkg::*;
#(
    parameter int WIDTH        = BC_WIDTH,
    parameter int DEPTH        = BC_DEPTH,
    parameter int AFULL_THRESH = BC_DEPTH - 4,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic             afull
`ifdef BC_LINK_STATS_EN
   ,output logic [BC_STAT_W-1:0] stall_cnt
`endif
);

    localparam int AW = CW - 1;
    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push;
    logic             pop;
    logic [CW-1:0]    count_nxt;

    assign in_rdy    = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr[AW-1:0]];
    assign push      = in_valid && in_rdy;
    assign pop       = out_valid && out_rdy;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CNT_ONE;
        else if (pop && !push)
            count_nxt = count - CNT_ONE;
    end

    // Flush discards any same-cycle push or pop by leaving wr_ptr alone and snapping rd_ptr to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            afull  <= 1'b0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
            afull  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_nxt;
            afull <= (count_nxt >= CW'(AFULL_THRESH));
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst)
            mem[wr_ptr[AW-1:0]] <= in_data;
    end

`ifdef BC_LINK_STATS_EN
    // Survives flush on purpose: it measures upstream stall history, not buffer contents.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (in_valid && !in_rdy && (stall_cnt != '1))
            stall_cnt <= stall_cnt + BC_STAT_ONE;
    end
`endif

endmodule

// File: rtl/bc_link_buffer.sv
// Bidirectional avoid<->ctrl buffer: two independent bc_fifo instances sharing only the clock.
// Latency: 1 cycle push-to-visible per direction; count/afull registered.
// Backpressure: each *_in_rdy drops only when its own direction is full. Macro BC_LINK_STATS_EN adds stall counters.
module bc_link_buffer
    import bc_pkg::*;
#(
    parameter int WIDTH        = BC_WIDTH,
    parameter int DEPTH        = BC_DEPTH,
    parameter int AFULL_THRESH = DEPTH - 4,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             avoid_in_valid,
    output logic             avoid_in_rdy,
    input  logic [WIDTH-1:0] avoid_in_data,
    output logic             ctrl_out_valid,
    input  logic             ctrl_out_rdy,
    output logic [WIDTH-1:0] ctrl_out_data,
    input  logic             ctrl_in_valid,
    output logic             ctrl_in_rdy,
    input  logic [WIDTH-1:0] ctrl_in_data,
    output logic             avoid_out_valid,
    input  logic             avoid_out_rdy,
    output logic [WIDTH-1:0] avoid_out_data,
    input  logic             a2c_flush,
    input  logic             c2a_flush,
    output logic [CW-1:0]    a2c_count,
    output logic [CW-1:0]    c2a_count,
    output logic             a2c_afull,
    output logic             c2a_afull
`ifdef BC_LINK_STATS_EN
   ,output logic [BC_STAT_W-1:0] a2c_stall_cnt,
    output logic [BC_STAT_W-1:0] c2a_stall_cnt
`endif
);

    bc_fifo #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL_THRESH)
    ) u_a2c (
        .clk       (clk),
        .rst       (rst),
        .flush     (a2c_flush),
        .in_valid  (avoid_in_valid),
        .in_rdy    (avoid_in_rdy),
        .in_data   (avoid_in_data),
        .out_valid (ctrl_out_valid),
        .out_rdy   (ctrl_out_rdy),
        .out_data  (ctrl_out_data),
        .count     (a2c_count),
        .afull     (a2c_afull)
`ifdef BC_LINK_STATS_EN
       ,.stall_cnt (a2c_stall_cnt)
`endif
    );

    bc_fifo #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL_THRESH)
    ) u_c2a (
        .clk       (clk),
        .rst       (rst),
        .flush     (c2a_flush),
        .in_valid  (ctrl_in_valid),
        .in_rdy    (ctrl_in_rdy),
        .in_data   (ctrl_in_data),
        .out_valid (avoid_out_valid),
        .out_rdy   (avoid_out_rdy),
        .out_data  (avoid_out_data),
        .count     (c2a_count),
        .afull     (c2a_afull)
`ifdef BC_LINK_STATS_EN
       ,.stall_cnt (c2a_stall_cnt)
`endif
    );

endmodule

// File: tb/tb_bc_link_buffer.sv
// Bench for bc_link_buffer: queue-based reference model checked every cycle, directed scenarios, random traffic.
module tb_bc_link_buffer;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int AT = 12;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          avoid_in_valid, avoid_in_rdy;
    logic [W-1:0]  avoid_in_data;
    logic          ctrl_out_valid, ctrl_out_rdy;
    logic [W-1:0]  ctrl_out_data;
    logic          ctrl_in_valid, ctrl_in_rdy;
    logic [W-1:0]  ctrl_in_data;
    logic          avoid_out_valid, avoid_out_rdy;
    logic [W-1:0]  avoid_out_data;
    logic          a2c_flush, c2a_flush;
    logic [CW-1:0] a2c_count, c2a_count;
    logic          a2c_afull, c2a_afull;
`ifdef BC_LINK_STATS_EN
    logic [15:0]   a2c_stall_cnt, c2a_stall_cnt;
`endif

    always #5 clk = ~clk;

    bc_link_buffer #(.WIDTH(W), .DEPTH(D), .AFULL_THRESH(AT)) dut (
        .clk             (clk),
        .rst             (rst),
        .avoid_in_valid  (avoid_in_valid),
        .avoid_in_rdy    (avoid_in_rdy),
        .avoid_in_data   (avoid_in_data),
        .ctrl_out_valid  (ctrl_out_valid),
        .ctrl_out_rdy    (ctrl_out_rdy),
        .ctrl_out_data   (ctrl_out_data),
        .ctrl_in_valid   (ctrl_in_valid),
        .ctrl_in_rdy     (ctrl_in_rdy),
        .ctrl_in_data    (ctrl_in_data),
        .avoid_out_valid (avoid_out_valid),
        .avoid_out_rdy   (avoid_out_rdy),
        .avoid_out_data  (avoid_out_data),
        .a2c_flush       (a2c_flush),
        .c2a_flush       (c2a_flush),
        .a2c_count       (a2c_count),
        .c2a_count       (c2a_count),
        .a2c_afull       (a2c_afull),
        .c2a_afull       (c2a_afull)
`ifdef BC_LINK_STATS_EN
       ,.a2c_stall_cnt   (a2c_stall_cnt),
        .c2a_stall_cnt   (c2a_stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each direction is a plain queue; stall counters are saturating ints.
    logic [W-1:0] qa[$];
    logic [W-1:0] qc[$];
    int  sa, sc;
    bit  armed = 1'b0;
    bit  pa, ua, pc, uc;

    always @(posedge clk) begin
        if (rst) begin
            qa.delete();
            qc.delete();
            sa = 0;
            sc = 0;
            armed = 1'b1;
        end else begin
            if (avoid_in_valid && qa.size() == D && sa < 65535) sa++;
            if (ctrl_in_valid && qc.size() == D && sc < 65535) sc++;
            pa = ctrl_out_rdy && qa.size() > 0;
            ua = avoid_in_valid && qa.size() < D;
            pc = avoid_out_rdy && qc.size() > 0;
            uc = ctrl_in_valid && qc.size() < D;
            if (a2c_flush) qa.delete();
            else begin
                if (pa) void'(qa.pop_front());
                if (ua) qa.push_back(avoid_in_data);
            end
            if (c2a_flush) qc.delete();
            else begin
                if (pc) void'(qc.pop_front());
                if (uc) qc.push_back(ctrl_in_data);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("a2c_in_rdy", avoid_in_rdy, qa.size() < D);
            check("a2c_out_valid", ctrl_out_valid, qa.size() > 0);
            check("a2c_count", a2c_count, qa.size());
            check("a2c_afull", a2c_afull, qa.size() >= AT);
            if (qa.size() > 0) check("a2c_out_data", ctrl_out_data, qa[0]);
            check("c2a_in_rdy", ctrl_in_rdy, qc.size() < D);
            check("c2a_out_valid", avoid_out_valid, qc.size() > 0);
            check("c2a_count", c2a_count, qc.size());
            check("c2a_afull", c2a_afull, qc.size() >= AT);
            if (qc.size() > 0) check("c2a_out_data", avoid_out_data, qc[0]);
`ifdef BC_LINK_STATS_EN
            check("a2c_stall", a2c_stall_cnt, sa);
            check("c2a_stall", c2a_stall_cnt, sc);
`endif
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        avoid_in_valid = 0; avoid_in_data = '0; ctrl_out_rdy = 0;
        ctrl_in_valid = 0;  ctrl_in_data = '0;  avoid_out_rdy = 0;
        a2c_flush = 0; c2a_flush = 0;
        repeat (2) cyc();
        check("rst_a2c_valid", ctrl_out_valid, 0);
        check("rst_c2a_valid", avoid_out_valid, 0);
        check("rst_a2c_rdy", avoid_in_rdy, 1);
        check("rst_c2a_rdy", ctrl_in_rdy, 1);
        check("rst_counts", {a2c_count, c2a_count}, 0);
        check("rst_afull", {a2c_afull, c2a_afull}, 0);
        rst = 1'b0;

        // Reverse direction ordering
        ctrl_in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            ctrl_in_data = W'(10 + i);
            cyc();
        end
        ctrl_in_valid = 0;
        check("rev_count10", c2a_count, 10);
        avoid_out_rdy = 1;
        for (int k = 0; k < 10; k++) begin
            check("rev_valid", avoid_out_valid, 1);
            check("rev_data", avoid_out_data, 10 + k);
            cyc();
        end
        check("rev_valid_drop", avoid_out_valid, 0);
        check("rev_count0", c2a_count, 0);
        avoid_out_rdy = 0;

        // Full and almost-full
        avoid_in_valid = 1;
        for (int i = 0; i < 16; i++) begin
            avoid_in_data = W'(100 + i);
            cyc();
            if (i == 10) check("afull_at11", a2c_afull, 0);
            if (i == 11) check("afull_at12", a2c_afull, 1);
        end
        avoid_in_data = W'(116);
        check("full_rdy", avoid_in_rdy, 0);
        check("full_count", a2c_count, 16);
        repeat (2) cyc();
        check("full_hold", a2c_count, 16);
        ctrl_out_rdy = 1;
        check("full_head", ctrl_out_data, 100);
        cyc();
        ctrl_out_rdy = 0;
        check("pop_refused_push", a2c_count, 15);
        check("pop_rdy", avoid_in_rdy, 1);
        cyc();
        check("held_accepted", a2c_count, 16);
        avoid_in_valid = 0;
        ctrl_out_rdy = 1;
        for (int k = 0; k < 16; k++) begin
            check("full_order", ctrl_out_data, 101 + k);
            cyc();
        end
        ctrl_out_rdy = 0;
        check("full_drained", a2c_count, 0);

        // Simultaneous push/pop across the index wrap
        avoid_in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            avoid_in_data = W'(200 + i);
            cyc();
        end
        ctrl_out_rdy = 1;
        for (int i = 0; i < 20; i++) begin
            avoid_in_data = W'(205 + i);
            check("pp_head", ctrl_out_data, 200 + i);
            cyc();
            check("pp_count5", a2c_count, 5);
        end
        avoid_in_valid = 0;
        ctrl_out_rdy = 0;

        // Flush mid-operation with a same-cycle push
        ctrl_in_valid = 1;
        for (int i = 0; i < 7; i++) begin
            ctrl_in_data = W'(300 + i);
            cyc();
        end
        ctrl_in_data = 16'hBEEF;
        c2a_flush = 1;
        cyc();
        ctrl_in_valid = 0;
        c2a_flush = 0;
        check("flush_count", c2a_count, 0);
        check("flush_valid", avoid_out_valid, 0);
        check("flush_rdy", ctrl_in_rdy, 1);
        check("flush_other_cnt", a2c_count, 5);
        check("flush_other_head", ctrl_out_data, 220);
        avoid_out_rdy = 1;
        repeat (3) begin
            cyc();
            check("no_beef", avoid_out_valid, 0);
        end
        avoid_out_rdy = 0;
        ctrl_out_rdy = 1;
        repeat (5) cyc();
        ctrl_out_rdy = 0;

`ifdef BC_LINK_STATS_EN
        rst = 1;
        cyc();
        rst = 0;
        avoid_in_valid = 1;
        repeat (16) cyc();
        repeat (4) cyc();
        check("stall4", a2c_stall_cnt, 4);
        avoid_in_valid = 0;
        a2c_flush = 1;
        cyc();
        a2c_flush = 0;
        check("stall_after_flush", a2c_stall_cnt, 4);
        check("stall_flush_cnt", a2c_count, 0);
`endif

        // Random traffic with phases of differing backpressure
        for (int n = 0; n < 4000; n++) begin
            int rp;
            rp = (((n / 200) % 3) == 0) ? 25 : ((((n / 200) % 3) == 1) ? 50 : 90);
            avoid_in_valid = ($urandom_range(99) < 60);
            ctrl_in_valid  = ($urandom_range(99) < 60);
            ctrl_out_rdy   = ($urandom_range(99) < rp);
            avoid_out_rdy  = ($urandom_range(99) < rp);
            avoid_in_data  = W'($urandom);
            ctrl_in_data   = W'($urandom);
            a2c_flush      = ($urandom_range(39) == 0);
            c2a_flush      = ($urandom_range(39) == 0);
            rst            = ($urandom_range(699) == 0);
            cyc();
        end
        rst = 0; a2c_flush = 0; c2a_flush = 0;
        avoid_in_valid = 0; ctrl_in_valid = 0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
